alu_share_ctrl: RTL and testbench

Sequencing controller that lets two requesters share the single combinational ALU in the datapath. It accepts one operation at a time through per-requester valid/ready handshakes and arbitrates round-robin. It drives the ALU control and operand inputs from registered state, captures the ALU result and zero flag, and returns them to the winning requester through a response handshake. It sits between the requesters (e.g. the main datapath and an address/branch helper) and the ALU instance.

---
 rtl/alu_share_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Lets two requesters share one combinational ALU. One operation is in flight
// at a time: a requester is accepted in IDLE, its operation drives the ALU from
// registered operands for one EXEC cycle, and the captured result is offered
// back to that requester in RESP until it is consumed. Ties are broken
// round-robin against the last requester that completed a response.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   req_valid    [1:0]        requester i has an operation pending
//   req_ready    [1:0]        requester i is accepted this cycle (one-hot or 0)
//   req_ctrl     [5:0]        ALU control for requester i at [3i+2:3i]
//   req_a/req_b  [2*WIDTH-1:0] operands for requester i at [WIDTH*i +: WIDTH]
//   rsp_valid    [1:0]        response available for requester i
//   rsp_ready    [1:0]        requester i consumes its response
//   rsp_result   [WIDTH-1:0]  captured result (shared by both requesters)
//   rsp_zero                  captured zero flag
//   rsp_err                   operation used an illegal control code
//   alu_ctrl/alu_a/alu_b      registered drive into the ALU
//   alu_result/alu_zero       combinational ALU outputs
//   busy                      controller is not in IDLE
//   fsm_state    [1:0]        current FSM state (debug visibility)
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready of the same bit are high. req_ready is a combinational
// function of req_valid and registered state; rsp_valid depends only on
// registered state and, once high, stays high with a stable payload until
// the owning requester's rsp_ready completes the transfer.
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_ctrl,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [2:0]         alu_ctrl,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SHL = 3'b111;

  state_t             state;
  state_t             state_next;

  logic               last;
  logic               owner;
  logic [2:0]         op_ctrl;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               err_q;

  logic               grant;
  logic               accept;
  logic               rsp_done;
  logic               ctrl_legal;
  logic [2:0]         sel_ctrl;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Round-robin pick: on a tie the requester that did not complete last wins,
  // otherwise whichever one is asking. Nothing is remembered for a requester
  // that withdraws before it is accepted.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req_valid[1];
    end
  end

  // Qualified with rst_n so req_ready reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign accept   = rst_n && (state == IDLE) && req_valid[grant];
  assign rsp_done = (state == RESP) && rsp_ready[owner];

  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    sel_ctrl = grant ? req_ctrl[5:3]           : req_ctrl[2:0];
    sel_a    = grant ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
    sel_b    = grant ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];
  end

  always_comb begin
    ctrl_legal = 1'b0;
    case (op_ctrl)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SHL: ctrl_legal = 1'b1;
      default:                                         ctrl_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operation, ownership and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      op_ctrl <= CTRL_ADD;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= grant;
        op_ctrl <= sel_ctrl;
        op_a    <= sel_a;
        op_b    <= sel_b;
      end
      if (state == EXEC) begin
        // The ALU keeps a stale output for undefined codes, so its result is
        // discarded and a clean error response is reported instead.
        if (ctrl_legal) begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          err_q  <= 1'b0;
        end else begin
          res_q  <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (rsp_done) begin
        last <= owner;
      end
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign alu_ctrl   = op_ctrl;
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Bench for alu_share_ctrl with a behavioural ALU attached. Directed cases
// cover first-op latency, round-robin fairness, response back-pressure,
// illegal codes, reset mid-operation and wrap/shift boundaries, followed by
// randomized traffic. Inputs change on the falling edge, outputs are checked
// on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [5:0]     req_ctrl = '0;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready = 2'b00;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           rsp_err;
  logic [2:0]     alu_ctrl;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           busy;
  logic [1:0]     fsm_state;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- ALU arithmetic (shared by the ALU model and reference) ---
  function automatic bit is_legal(input logic [2:0] c);
    return (c == 3'b010) || (c == 3'b110) || (c == 3'b000) ||
           (c == 3'b001) || (c == 3'b111);
  endfunction

  function automatic logic [W-1:0] alu_math(input logic [2:0] c,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (c)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return (b >= W) ? '0 : (a << b[4:0]);
      default: return '0;
    endcase
  endfunction

  // The ALU presents junk for undefined codes, with zero asserted, so a
  // controller that forwards it is exposed.
  always_comb begin
    if (is_legal(alu_ctrl)) begin
      alu_result = alu_math(alu_ctrl, alu_a, alu_b);
      alu_zero   = (alu_math(alu_ctrl, alu_a, alu_b) == '0);
    end else begin
      alu_result = {16'hBAD0, alu_a[15:0] ^ 16'h5A5A};
      alu_zero   = 1'b1;
    end
  end

  // Expected response payload {err, zero, result}
  function automatic logic [W+1:0] ref_rsp(input logic [2:0] c,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    if (!is_legal(c)) return {2'b10, {W{1'b0}}};
    r = alu_math(c, a, b);
    return {1'b0, (r == '0), r};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  bit           m_busy;     // an operation is in flight
  bit           m_resp;     // its response is visible
  bit           m_owner;
  bit           m_last;     // requester that completed most recently
  logic [2:0]   m_ctrl;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W+1:0] m_hold;     // {err, zero, result} currently held
  logic [W+1:0] exp_q[$];   // responses owed, oldest first
  int           acc_cyc[$];
  bit           acc_who[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_resp  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_ctrl  = 3'b010;
    m_a     = '0;
    m_b     = '0;
    m_hold  = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [1:0] exp_vld;
    exp_vld = (m_busy && m_resp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check("rsp_valid",  rsp_valid, exp_vld);
    check("busy",       busy, m_busy);
    check("rsp_result", rsp_result, m_hold[W-1:0]);
    check("rsp_zero",   rsp_zero, m_hold[W]);
    check("rsp_err",    rsp_err, m_hold[W+1]);
    check("alu_ctrl",   alu_ctrl, m_ctrl);
    check("alu_a",      alu_a, m_a);
    check("alu_b",      alu_b, m_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input bit idx, input logic [2:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    if (idx) begin
      req_ctrl[5:3]     = c;
      req_a[2*W-1:W]    = a;
      req_b[2*W-1:W]    = b;
    end else begin
      req_ctrl[2:0]     = c;
      req_a[W-1:0]      = a;
      req_b[W-1:0]      = b;
    end
  endtask

  // One clock: entered and left on a falling edge.
  task automatic step(input logic [1:0] v, input logic [1:0] rr);
    bit         g;
    logic [1:0] exp_rdy;
    req_valid = v;
    rsp_ready = rr;
    #1;
    g       = (v == 2'b11) ? ~m_last : v[1];
    exp_rdy = (!m_busy && v[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", req_ready, exp_rdy);
    if (exp_rdy != 2'b00) begin
      m_busy  = 1'b1;
      m_resp  = 1'b0;
      m_owner = g;
      m_ctrl  = g ? req_ctrl[5:3]  : req_ctrl[2:0];
      m_a     = g ? req_a[2*W-1:W] : req_a[W-1:0];
      m_b     = g ? req_b[2*W-1:W] : req_b[W-1:0];
      exp_q.push_back(ref_rsp(m_ctrl, m_a, m_b));
      acc_cyc.push_back(cyc);
      acc_who.push_back(g);
    end else if (m_busy && !m_resp) begin
      m_resp = 1'b1;
      m_hold = exp_q[0];
    end else if (m_busy && m_resp && rr[m_owner]) begin
      check("rsp_payload", {rsp_err, rsp_zero, rsp_result}, exp_q.pop_front());
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_last = m_owner;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_req_ready", req_ready, 2'b00);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    check("rst_req_ready_hold", req_ready, 2'b00);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [2:0] legal_tab [5];
    legal_tab[0] = 3'b010; legal_tab[1] = 3'b110; legal_tab[2] = 3'b000;
    legal_tab[3] = 3'b001; legal_tab[4] = 3'b111;

    model_reset();
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    check("reset_req_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // First op: add 5+7, response 2 edges after accept
    set_op(0, 3'b010, 32'd5, 32'd7);
    step(2'b01, 2'b11);
    step(2'b00, 2'b11);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_result", rsp_result, 32'd12);
    check("t1_zero", rsp_zero, 1'b0);
    check("t1_err", rsp_err, 1'b0);
    step(2'b00, 2'b11);

    // Fresh tie-break state, both requesters continuously valid
    do_reset();
    set_op(0, 3'b110, 32'd3, 32'd3);
    set_op(1, 3'b111, 32'd1, 32'd4);
    s = acc_who.size();
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 2'b11);
      if (i == 1) check("t2_req0_zero", {rsp_zero, rsp_result}, {1'b1, 32'd0});
      if (i == 4) check("t2_req1_result", rsp_result, 32'd16);
    end
    check("t2_accept_count", acc_who.size() - s, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", acc_who[s+i], i % 2);
      if (i > 0) check("t2_spacing", acc_cyc[s+i] - acc_cyc[s+i-1], 3);
    end

    // Back-pressure on requester 1 with requester 0 waiting
    set_op(1, 3'b001, 32'hF0, 32'h0F);
    set_op(0, 3'b010, 32'd9, 32'd9);
    step(2'b10, 2'b00);
    step(2'b01, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 2'b01);
      check("t3_hold_result", rsp_result, 32'hFF);
      check("t3_hold_valid", rsp_valid, 2'b10);
    end
    s = acc_who.size();
    step(2'b01, 2'b10);
    check("t3_no_accept_on_consume", acc_who.size() - s, 0);
    step(2'b01, 2'b11);
    check("t3_req0_accept", acc_who.size() - s, 1);
    step(2'b00, 2'b11);
    step(2'b00, 2'b11);

    // Illegal code, then legal add
    set_op(0, 3'b100, 32'h1234, 32'h1);
    step(2'b01, 2'b11);
    step(2'b00, 2'b11);
    check("t4_illegal", {rsp_err, rsp_zero, rsp_result}, {2'b10, 32'd0});
    step(2'b00, 2'b11);
    set_op(0, 3'b010, 32'd1, 32'd1);
    step(2'b01, 2'b11);
    step(2'b00, 2'b11);
    check("t4_legal_after", {rsp_err, rsp_zero, rsp_result}, {2'b00, 32'd2});
    step(2'b00, 2'b11);

    // Reset in the middle of EXEC; tie afterwards goes to requester 0
    set_op(0, 3'b010, 32'd20, 32'd22);
    set_op(1, 3'b001, 32'd3, 32'd4);
    step(2'b10, 2'b00);
    req_valid = 2'b11;
    do_reset();
    s = acc_who.size();
    step(2'b11, 2'b11);
    check("t5_tie_after_reset", acc_who[s], 1'b0);
    step(2'b00, 2'b11);
    check("t5_result", rsp_result, 32'd42);
    step(2'b00, 2'b11);

    // Wrap-around and oversized shift
    set_op(0, 3'b010, 32'hFFFF_FFFF, 32'd1);
    step(2'b01, 2'b11);
    step(2'b00, 2'b11);
    check("t6_wrap", {rsp_zero, rsp_result}, {1'b1, 32'd0});
    step(2'b00, 2'b11);
    set_op(1, 3'b111, 32'd1, 32'd40);
    step(2'b10, 2'b11);
    step(2'b00, 2'b11);
    check("t6_shl40", {rsp_zero, rsp_result}, {1'b1, 32'd0});
    step(2'b00, 2'b11);

    // Randomized traffic: operands change every cycle, only accept-edge values count
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 2; r++) begin
        logic [2:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        c = ($urandom_range(0, 9) < 8) ? legal_tab[$urandom_range(0, 4)]
                                       : 3'($urandom_range(3, 5));
        case ($urandom_range(0, 3))
          0:       a = 32'hFFFF_FFFF;
          1:       a = 32'($urandom_range(0, 3));
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       b = 32'($urandom_range(0, 40));
          1:       b = a;
          default: b = $urandom;
        endcase
        set_op(r[0], c, a, b);
      end
      step(2'($urandom_range(0, 3)),
           {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)});
    end
    repeat (4) step(2'b00, 2'b11);
    check("final_idle", busy, 1'b0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
